// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path: geometry defaults,
// controller state encoding and the RGB565 -> RGB332 pixel packer.
package cam_pkg;

    localparam int DEF_H_PIX = 160;
    localparam int DEF_V_PIX = 120;
    localparam int DEF_AW    = 15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_FRAME   = 2'd2
    } cap_state_t;

    // Keep the top 3 red, top 3 green and top 2 blue bits of the byte pair.
    function automatic logic [7:0] rgb565_to_rgb332(
        input logic [7:0] hi,
        input logic [7:0] lo
    );
        return {hi[7:5], hi[2:0], lo[4:3]};
    endfunction

endpackage

// File: rtl/cam_in_sync.sv
// Brings the raw camera port into the clk domain and turns the
// pclk/href/vsync levels into single-cycle edge strobes.
module cam_in_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       pclk,
    input  logic       vsync,
    input  logic       href,
    input  logic [7:0] px_data,
    output logic       pclk_rise,
    output logic       href_rise,
    output logic       href_fall,
    output logic       href_lvl,
    output logic       vsync_rise,
    output logic       vsync_fall,
    output logic [7:0] data
);

    // bit 0 = first sync stage, bit 1 = second stage, bit 2 = history
    logic [2:0] pclk_sr;
    logic [2:0] vsync_sr;
    logic [2:0] href_sr;
    logic [7:0] data_s1;
    logic [7:0] data_s2;

    // Two-flop synchronizers with one extra history flop for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_sr  <= '0;
            vsync_sr <= '0;
            href_sr  <= '0;
            data_s1  <= '0;
            data_s2  <= '0;
        end else begin
            pclk_sr  <= {pclk_sr[1:0], pclk};
            vsync_sr <= {vsync_sr[1:0], vsync};
            href_sr  <= {href_sr[1:0], href};
            data_s1  <= px_data;
            data_s2  <= data_s1;
        end
    end

    assign pclk_rise  = pclk_sr[1] & ~pclk_sr[2];
    assign href_rise  = href_sr[1] & ~href_sr[2];
    assign href_fall  = ~href_sr[1] & href_sr[2];
    assign href_lvl   = href_sr[1];
    assign vsync_rise = vsync_sr[1] & ~vsync_sr[2];
    assign vsync_fall = ~vsync_sr[1] & vsync_sr[2];
    assign data       = data_s2;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Camera capture sequencer: frames camera bytes into RGB332 pixels and
// writes them to a raster-addressed frame buffer, one frame at a time.
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int H_PIX = DEF_H_PIX,
    parameter int V_PIX = DEF_V_PIX,
    parameter int AW    = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          continuous,
    input  logic          CAM_pclk,
    input  logic          CAM_vsync,
    input  logic          CAM_href,
    input  logic [7:0]    CAM_px_data,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_data,
    output logic          mem_we,
    output logic          busy,
    output logic          frame_done,
    output logic          err_line,
    output logic          err_frame
);

    // counters saturate one past the nominal size to flag overruns
    localparam int PW = $clog2(H_PIX + 2);
    localparam int LW = $clog2(V_PIX + 2);

    localparam logic [PW-1:0] PIX_END   = PW'(H_PIX);
    localparam logic [PW-1:0] PIX_SAT   = PW'(H_PIX + 1);
    localparam logic [LW-1:0] LINE_END  = LW'(V_PIX);
    localparam logic [LW-1:0] LINE_SAT  = LW'(V_PIX + 1);
    localparam logic [AW-1:0] LINE_STEP = AW'(H_PIX);

    logic       pclk_rise;
    logic       href_rise;
    logic       href_fall;
    logic       href_lvl;
    logic       vsync_rise;
    logic       vsync_fall;
    logic [7:0] cam_byte;

    cam_in_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .pclk       (CAM_pclk),
        .vsync      (CAM_vsync),
        .href       (CAM_href),
        .px_data    (CAM_px_data),
        .pclk_rise  (pclk_rise),
        .href_rise  (href_rise),
        .href_fall  (href_fall),
        .href_lvl   (href_lvl),
        .vsync_rise (vsync_rise),
        .vsync_fall (vsync_fall),
        .data       (cam_byte)
    );

    cap_state_t    state, state_n;
    logic [LW-1:0] line, line_n;
    logic [AW-1:0] line_base, base_n;
    logic [PW-1:0] pix, pix_n;
    logic          phase, phase_n;
    logic [7:0]    hi, hi_n;
    logic          we_n;
    logic [AW-1:0] addr_n;
    logic [7:0]    data_n;
    logic          done_n;
    logic          errl_n;
    logic          errf_n;

    // State, counters and all outputs are registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            line       <= '0;
            line_base  <= '0;
            pix        <= '0;
            phase      <= 1'b0;
            hi         <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err_line   <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            state      <= state_n;
            line       <= line_n;
            line_base  <= base_n;
            pix        <= pix_n;
            phase      <= phase_n;
            hi         <= hi_n;
            mem_we     <= we_n;
            mem_addr   <= addr_n;
            mem_data   <= data_n;
            busy       <= (state_n != ST_IDLE);
            frame_done <= done_n;
            err_line   <= errl_n;
            err_frame  <= errf_n;
        end
    end

    // Next state; same-cycle events apply as pixel, href fall, vsync rise
    always_comb begin
        state_n = state;
        line_n  = line;
        base_n  = line_base;
        pix_n   = pix;
        phase_n = phase;
        hi_n    = hi;
        we_n    = 1'b0;
        addr_n  = mem_addr;
        data_n  = mem_data;
        done_n  = 1'b0;
        errl_n  = err_line;
        errf_n  = err_frame;

        unique case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_n = ST_WAIT_VS;
                    errl_n  = 1'b0;
                    errf_n  = 1'b0;
                end
            end

            ST_WAIT_VS: begin
                if (stop) begin
                    state_n = ST_IDLE;
                end else if (vsync_fall) begin
                    state_n = ST_FRAME;
                    line_n  = '0;
                    base_n  = '0;
                    pix_n   = '0;
                    phase_n = 1'b0;
                end
            end

            ST_FRAME: begin
                if (stop) begin
                    state_n = ST_IDLE;
                end else begin
                    if (href_rise) begin
                        pix_n   = '0;
                        phase_n = 1'b0;
                    end
                    if (pclk_rise && href_lvl) begin
                        if (!phase_n) begin
                            hi_n    = cam_byte;
                            phase_n = 1'b1;
                        end else begin
                            phase_n = 1'b0;
                            if (pix_n < PIX_END && line < LINE_END) begin
                                we_n   = 1'b1;
                                addr_n = line_base + AW'(pix_n);
                                data_n = rgb565_to_rgb332(hi, cam_byte);
                            end
                            if (pix_n != PIX_SAT) begin
                                pix_n = pix_n + 1'b1;
                            end
                        end
                    end
                    if (href_fall) begin
                        if (pix_n != PIX_END || phase_n) begin
                            errl_n = 1'b1;
                        end
                        if (line < LINE_END) begin
                            base_n = line_base + LINE_STEP;
                        end
                        if (line != LINE_SAT) begin
                            line_n = line + 1'b1;
                        end
                    end
                    if (vsync_rise) begin
                        done_n = 1'b1;
                        if (line_n != LINE_END) begin
                            errf_n = 1'b1;
                        end
                        state_n = continuous ? ST_WAIT_VS : ST_IDLE;
                    end
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

endmodule
